// File: rtl/ctrl_pkg.sv
// Shared types and constants for the RV32I multicycle control path.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_RD,
        MEM_WR,
        ALU_WB,
        LD_WB,
        BRANCH,
        TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } instr_class_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode decode: instruction class and immediate-generator select.
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] instr_class,
    output logic [2:0] imm_src
);

    always_comb begin
        instr_class = CLS_ILLEGAL;
        imm_src     = IMM_I;
        case (opcode)
            OPC_R:      instr_class = CLS_R;
            OPC_I:      instr_class = CLS_I;
            OPC_LOAD:   instr_class = CLS_LOAD;
            OPC_STORE: begin
                instr_class = CLS_STORE;
                imm_src     = IMM_S;
            end
            OPC_BRANCH: begin
                instr_class = CLS_BRANCH;
                imm_src     = IMM_B;
            end
            default:    instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM with memory handshake, timeout and sticky trap.
// Optional performance counters are built when PERF_CNT_EN is defined.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             br_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic [2:0]       imm_src,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             trap,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_e           state;
    state_e           state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]       imm_q;
    logic [2:0]       dec_cls_raw;
    logic [2:0]       dec_imm;
    instr_class_e     dec_cls;
    logic             in_req;
    logic             timed_out;
    logic             unused_instr_bits;

    main_decoder u_main_decoder (
        .opcode      (instr[6:0]),
        .instr_class (dec_cls_raw),
        .imm_src     (dec_imm)
    );

    assign dec_cls           = instr_class_e'(dec_cls_raw);
    assign unused_instr_bits = ^instr[31:7];

    assign in_req    = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign timed_out = (TIMEOUT_CYC != 0) && (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Counts wait cycles of the current request; restarts whenever a request state is entered.
    always_ff @(posedge clk) begin
        if (rst || !in_req || (state_next != state)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q <= IMM_I;
        end else if (state == DECODE) begin
            imm_q <= dec_imm;
        end
    end

    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        imm_src      = imm_q;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        reg_we       = 1'b0;
        wb_sel       = 1'b0;
        trap         = 1'b0;

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = DECODE;
                end else if (timed_out) begin
                    state_next = TRAP;
                end
            end
            DECODE: begin
                case (dec_cls)
                    CLS_R:                state_next = EXEC_R;
                    CLS_I:                state_next = EXEC_I;
                    CLS_LOAD, CLS_STORE:  state_next = MEM_ADDR;
                    CLS_BRANCH:           state_next = BRANCH;
                    default:              state_next = TRAP;
                endcase
            end
            EXEC_R: begin
                alu_op     = ALU_FUNCT;
                state_next = ALU_WB;
            end
            EXEC_I: begin
                alu_src_b  = 1'b1;
                alu_op     = ALU_FUNCT;
                state_next = ALU_WB;
            end
            MEM_ADDR: begin
                alu_src_b  = 1'b1;
                state_next = (dec_cls == CLS_STORE) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    state_next = LD_WB;
                end else if (timed_out) begin
                    state_next = TRAP;
                end
            end
            MEM_WR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ready) begin
                    state_next = FETCH;
                end else if (timed_out) begin
                    state_next = TRAP;
                end
            end
            ALU_WB: begin
                reg_we     = 1'b1;
                state_next = FETCH;
            end
            LD_WB: begin
                reg_we     = 1'b1;
                wb_sel     = 1'b1;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_op     = ALU_SUB;
                pc_src     = 1'b1;
                pc_we      = br_taken;
                state_next = FETCH;
            end
            TRAP: begin
                trap = 1'b1;
            end
            default: state_next = FETCH;
        endcase

        // Reset cycle: suppress every strobe so a dropped request leaves no side effects.
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            pc_src       = 1'b0;
            imm_src      = IMM_I;
            alu_src_b    = 1'b0;
            alu_op       = ALU_ADD;
            reg_we       = 1'b0;
            wb_sel       = 1'b0;
            trap         = 1'b0;
        end
    end

`ifdef PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retired_q;

    assign retire = !rst && ((state == ALU_WB) || (state == LD_WB) || (state == BRANCH) ||
                             ((state == MEM_WR) && mem_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_q;
    assign retired_cnt = retired_q;
`else
    assign cycle_cnt   = '0;
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a per-instruction cycle-trace model.
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;
    localparam int T     = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      instr = '0;
    logic             br_taken = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src;
    logic [2:0]       imm_src;
    logic             alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_we, wb_sel, trap;
    logic [CNT_W-1:0] retired_cnt, cycle_cnt;

    multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .imm_src(imm_src), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel), .trap(trap),
        .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    // One record per clock: inputs to apply and the outputs the instruction's rules require.
    typedef struct {
        logic        rst;
        logic        rdy;
        logic        br;
        logic [31:0] ins;
        logic [14:0] exp;
        logic        upd;
        logic [2:0]  nimm;
        logic        ret;
        int          tag;
        logic        first;
    } rec_t;

    rec_t q[$];
    rec_t build[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    int       reg_we_idx[8];
    int       mem_req_n[8], mem_we_n[8], reg_we_n[8], pc_we_n[8], wbsel_n[8], trap_n[8];
    logic [2:0] imm_last[8];

    function automatic logic [14:0] o(input logic req, input logic we, input logic asel,
                                      input logic irwe, input logic pcwe, input logic pcsrc,
                                      input logic bsrc, input logic [1:0] aop, input logic rwe,
                                      input logic wsel, input logic trp);
        return {req, we, asel, irwe, pcwe, pcsrc, 3'b000, bsrc, aop, rwe, wsel, trp};
    endfunction

    function automatic rec_t mk(input logic [14:0] e, input logic rdy, input logic [31:0] ins,
                                input int tag);
        rec_t r;
        r.rst = 1'b0; r.rdy = rdy; r.br = 1'($urandom_range(0, 1)); r.ins = ins; r.exp = e;
        r.upd = 1'b0; r.nimm = 3'b000; r.ret = 1'b0; r.tag = tag; r.first = 1'b0;
        return r;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push_mem(input int d, input logic we, input logic [31:0] ins, input int tag,
                            output logic trapped);
        for (int i = 0; i < d && i < T; i++)
            build.push_back(mk(o(1, we, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0), 1'b0, ins, tag));
        trapped = (d >= T);
        if (!trapped)
            build.push_back(mk(o(1, we, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0), 1'b1, ins, tag));
    endtask

    // kind: 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 illegal
    task automatic gen(input int kind, input int df, input int dm, input logic br,
                       input int tag, input int abort_at, input logic [31:0] fix);
        logic [31:0] u, ins;
        logic [6:0]  opc;
        logic        trapped;
        rec_t        r;
        build.delete();
        u = $urandom();
        case (kind)
            0: opc = 7'b0110011;
            1: opc = 7'b0010011;
            2: opc = 7'b0000011;
            3: opc = 7'b0100011;
            4: opc = 7'b1100011;
            default: begin
                do opc = 7'($urandom_range(0, 127));
                while (opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011});
            end
        endcase
        ins = (fix != '0) ? fix : {u[31:7], opc};
        trapped = 1'b0;

        for (int i = 0; i < df && i < T; i++)
            build.push_back(mk(o(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0), 1'b0, ins, tag));
        if (df >= T) trapped = 1'b1;
        else build.push_back(mk(o(1, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0), 1'b1, ins, tag));

        if (!trapped) begin
            r = mk('0, rb(), ins, tag);
            r.upd = 1'b1;
            r.nimm = (kind == 3) ? 3'b001 : (kind == 4) ? 3'b010 : 3'b000;
            build.push_back(r);
            case (kind)
                0, 1: begin
                    build.push_back(mk(o(0, 0, 0, 0, 0, 0, 1'(kind), 2'b10, 0, 0, 0), rb(), ins, tag));
                    r = mk(o(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0), rb(), ins, tag);
                    r.ret = 1'b1;
                    build.push_back(r);
                end
                2, 3: begin
                    build.push_back(mk(o(0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0), rb(), ins, tag));
                    push_mem(dm, 1'(kind == 3), ins, tag, trapped);
                    if (!trapped && kind == 3) build[build.size()-1].ret = 1'b1;
                    if (!trapped && kind == 2) begin
                        r = mk(o(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0), rb(), ins, tag);
                        r.ret = 1'b1;
                        build.push_back(r);
                    end
                end
                4: begin
                    r = mk(o(0, 0, 0, 0, br, 1, 0, 2'b01, 0, 0, 0), rb(), ins, tag);
                    r.br = br;
                    r.ret = 1'b1;
                    build.push_back(r);
                end
                default: trapped = 1'b1;
            endcase
        end

        if (trapped) begin
            for (int i = 0; i < 3; i++)
                build.push_back(mk(o(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1), rb(), ins, tag));
            r = mk('0, rb(), ins, tag);
            r.rst = 1'b1;
            build.push_back(r);
        end
        build[0].first = 1'b1;

        if (abort_at > 0 && abort_at < build.size()) begin
            while (build.size() > abort_at) void'(build.pop_back());
            r = mk('0, rb(), ins, tag);
            r.rst = 1'b1;
            build.push_back(r);
        end
        foreach (build[i]) q.push_back(build[i]);
    endtask

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        rec_t        r;
        logic [14:0] got, e;
        logic [2:0]  imm_cur;
        logic [CNT_W-1:0] cyc_exp, ret_exp, ecyc, eret;
        int          cyc, idx;

        foreach (reg_we_idx[i]) begin
            reg_we_idx[i] = -1; mem_req_n[i] = 0; mem_we_n[i] = 0; reg_we_n[i] = 0;
            pc_we_n[i] = 0; wbsel_n[i] = 0; trap_n[i] = 0; imm_last[i] = 3'b111;
        end

        gen(0, 0, 0, 1'b0, 0, -1, 32'h0020_81B3);   // ADD x3,x1,x2
        gen(2, 0, 3, 1'b0, 1, -1, 32'h0000_2083);   // LW, ready delayed 3
        gen(3, 0, 0, 1'b0, 2, -1, 32'h0020_A023);   // SW
        gen(4, 0, 0, 1'b1, 3, -1, 32'h0020_8463);   // BEQ taken
        gen(4, 0, 0, 1'b0, 4, -1, 32'h0020_8463);   // BEQ not taken
        gen(5, 0, 0, 1'b0, 5, -1, 32'h0000_007F);   // illegal opcode
        gen(2, 0, 9, 1'b0, 6, -1, 32'h0000_2083);   // load that never completes
        gen(3, 0, 9, 1'b0, 7, 5, 32'h0020_A023);    // reset during MEM_WR wait
        for (int n = 0; n < 300; n++) begin
            int k, df, dm, ab;
            k  = ($urandom_range(0, 19) == 0) ? 5 : int'($urandom_range(0, 4));
            df = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            dm = ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 6)) : -1;
            gen(k, df, dm, 1'($urandom_range(0, 1)), -1, ab, '0);
        end

        imm_cur = 3'b000; cyc_exp = '0; ret_exp = '0; cyc = 0; idx = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        while (q.size() > 0) begin
            r = q.pop_front();
            rst = r.rst; mem_ready = r.rdy; br_taken = r.br; instr = r.ins;
            @(negedge clk);
            got = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, imm_src,
                   alu_src_b, alu_op, reg_we, wb_sel, trap};
            e = r.exp;
            e[8:6] = r.rst ? 3'b000 : imm_cur;
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL outputs cycle=%0d tag=%0d got=%h exp=%h", cyc, r.tag, got, e);
            end
            if (!r.rst) begin
`ifdef PERF_CNT_EN
                ecyc = cyc_exp; eret = ret_exp;
`else
                ecyc = '0; eret = '0;
`endif
                n_cmp++;
                if (cycle_cnt !== ecyc || retired_cnt !== eret) begin
                    n_bad++;
                    $display("FAIL counters cycle=%0d got cyc=%0d ret=%0d exp cyc=%0d ret=%0d",
                             cyc, cycle_cnt, retired_cnt, ecyc, eret);
                end
            end

            idx = r.first ? 0 : idx + 1;
            if (r.tag >= 0 && r.tag < 8) begin
                if (reg_we && reg_we_idx[r.tag] < 0) reg_we_idx[r.tag] = idx;
                mem_req_n[r.tag] += int'(mem_req);
                mem_we_n[r.tag]  += int'(mem_we);
                reg_we_n[r.tag]  += int'(reg_we);
                pc_we_n[r.tag]   += int'(pc_we);
                wbsel_n[r.tag]   += int'(wb_sel);
                trap_n[r.tag]    += int'(trap);
                imm_last[r.tag]  = imm_src;
            end

            if (r.rst) begin
                imm_cur = 3'b000; cyc_exp = '0; ret_exp = '0;
            end else begin
                cyc_exp = cyc_exp + 1;
                if (r.ret) ret_exp = ret_exp + 1;
                if (r.upd) imm_cur = r.nimm;
            end
            cyc++;
            @(posedge clk);
            #1;
        end

        check("add_reg_we_cycle_index", reg_we_idx[0], 3);
        check("lw_mem_req_cycles", mem_req_n[1], 5);
        check("lw_wb_sel_cycles", wbsel_n[1], 1);
        check("lw_imm_src", int'(imm_last[1]), 0);
        check("sw_mem_we_cycles", mem_we_n[2], 1);
        check("sw_reg_we_cycles", reg_we_n[2], 0);
        check("sw_imm_src", int'(imm_last[2]), 1);
        check("beq_taken_pc_we_cycles", pc_we_n[3], 2);
        check("beq_imm_src", int'(imm_last[3]), 2);
        check("beq_not_taken_pc_we_cycles", pc_we_n[4], 1);
        check("illegal_trap_cycles", trap_n[5], 3);
        check("illegal_mem_req_cycles", mem_req_n[5], 1);
        check("timeout_mem_req_cycles", mem_req_n[6], 1 + T);
        check("timeout_trap_cycles", trap_n[6], 3);
        check("sw_reset_mem_we_cycles", mem_we_n[7], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
